sha256_w_schedule: RTL and testbench
====================================

// Module: sha256_w_schedule
// PURPOSE
//  Message-schedule generator feeding the SHA-256 compression datapath.
//  - Accepts one 512-bit block as 16 x 32-bit words over a valid/ready handshake.
//  - Expands the block into W[0..63] in a 16-word sliding window.
//  - Presents one W word per round on w_data, advanced by the compressor's w_next strobe.
// PARAMETERS
//  WORD_W      32  word width; fixed at 32 for SHA-256.
//  BLOCK_WORDS 16  words per block and window depth.
//  NUM_ROUNDS  64  rounds per block; sets the w_round terminal count (63).
// PORTS
//  clk         in   1   single clock, rising edge.
//  rst         in   1   asynchronous, active-high reset.
//  abort       in   1   synchronous clear back to LOAD; the current block is discarded.
//  word_valid  in   1   block word on word_data is valid.
//  word_ready  out  1   scheduler accepts a block word this cycle.
//  word_data   in   32  block word, big-endian order, W[0] first.
//  w_valid     out  1   w_data holds W[w_round].
//  w_next      in   1   compressor consumed the current W; advance one round.
//  w_data      out  32  W[t] for the current round.
//  w_round     out  6   current round index t, 0..63.
//  w_first     out  1   w_valid && w_round==0; compressor uses it to start init_round.
//  w_last      out  1   w_valid && w_round==63.
//  block_done  out  1   one-cycle pulse after round 63 is consumed.
// BEHAVIOUR
//  Reset (rst=1, async):
//  - state=LOAD; window win[0..15]=0; load_cnt=0; w_round=0.
//  - word_ready=1 once rst deasserts (0 while rst=1); w_valid=0, w_data=0, w_first=0,
//    w_last=0, block_done=0.
//  - Reset mid-block drops all progress; there is no partial-block resume.
//  States: LOAD -> RUN -> LOAD. Both state and outputs are registered.
//  LOAD:
//  - word_ready=1, w_valid=0.
//  - On word_valid&&word_ready: win[i]<=win[i+1], win[15]<=word_data, load_cnt++.
//  - On the 16th accept: state<=RUN, w_round<=0, load_cnt<=0.
//  - After the 16th accept, win[0]=W[0]. w_valid rises the next cycle, so latency is
//    1 clk from the last word to W[0].
//  RUN:
//  - word_ready=0; words offered on word_valid are not taken.
//  - w_valid=1, w_data=win[0], w_round=t.
//  - On w_next: win[i]<=win[i+1] for i<15, and
//    win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0]   (mod 2^32, adds truncated).
//    - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
//    - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//  - w_round increments on each w_next. With w_next held high, one W is issued per clk.
//  - w_next low: window and w_round hold; w_data stays stable.
//  - w_next at w_round==63: state<=LOAD, block_done<=1 for one cycle, window contents
//    don't care. The next block may start being accepted in the cycle after.
//  Boundary rules:
//  - w_next while w_valid=0 is ignored. word_valid in RUN is ignored.
//  - abort=1 (sync, any state): same effect as reset except no async path.
//    abort has priority over w_next and word_valid in the same cycle.
//  - w_data is forced to 0 whenever w_valid=0.
// TESTING
//  1. Reset:
//     rst pulse mid-RUN at round 20 -> next cycle w_valid=0, word_ready=1, w_round=0,
//     block_done=0.
//  2. "abc" padded block:
//     - Stimulus: 0x61626380, 14 x 0x0, 0x00000018; w_next held 1.
//     - Required: W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB,
//       block_done pulses 1 clk after W63.
//  3. Stall:
//     - Stimulus: w_next=0 for 5 clks at round 30.
//     - Required: w_data and w_round stable; resume yields the same W31 as a stall-free run.
//  4. Load backpressure:
//     - Stimulus: word_valid toggles 1/0 every cycle.
//     - Required: 16 accepts exactly; W[0..15] equal the words in order;
//       word_ready=0 once in RUN.
//  5. Abort:
//     - Stimulus: abort asserted together with w_next at round 40.
//     - Required: no advance to 41; LOAD next cycle; the following "abc" block reproduces
//       test 2.
//  6. Back-to-back blocks:
//     - Stimulus: second block presented immediately after block_done.
//     - Required: 16-clk load then W[0] of the new block; no residue from the first block.

Source files
------------

// File: rtl/sha256_w_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then issues W[0..63] one per round
// from a 16-word sliding window, advanced by the compressor's w_next strobe.
module sha256_w_schedule #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int NUM_ROUNDS  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    output logic              w_valid,
    input  logic              w_next,
    output logic [WORD_W-1:0] w_data,
    output logic [5:0]        w_round,
    output logic              w_first,
    output logic              w_last,
    output logic              block_done
);

    localparam int CW = $clog2(BLOCK_WORDS);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_win [BLOCK_WORDS];
    logic [CW-1:0]     r_cnt;
    logic [5:0]        r_round;
    logic              r_valid;
    logic              r_rdy;
    logic              r_done;

    logic [WORD_W-1:0] w_s0;
    logic [WORD_W-1:0] w_s1;
    logic [WORD_W-1:0] w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        w_s0  = rotr(r_win[1], 7) ^ rotr(r_win[1], 18) ^ (r_win[1] >> 3);
        w_s1  = rotr(r_win[14], 17) ^ rotr(r_win[14], 19) ^ (r_win[14] >> 10);
        w_new = w_s1 + r_win[9] + w_s0 + r_win[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
            for (int i = 0; i < BLOCK_WORDS; i++) r_win[i] <= '0;
            r_cnt   <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= S_LOAD;
            for (int i = 0; i < BLOCK_WORDS; i++) r_win[i] <= '0;
            r_cnt   <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    if (word_valid && r_rdy) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) r_win[i] <= r_win[i+1];
                        r_win[BLOCK_WORDS-1] <= word_data;
                        if (r_cnt == CW'(BLOCK_WORDS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                            r_round <= '0;
                            r_valid <= 1'b1;
                            r_rdy   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_next && r_valid) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) r_win[i] <= r_win[i+1];
                        r_win[BLOCK_WORDS-1] <= w_new;
                        if (r_round == 6'(NUM_ROUNDS - 1)) begin
                            r_state <= S_LOAD;
                            r_round <= '0;
                            r_valid <= 1'b0;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_round <= r_round + 1'b1;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // ready is held low for the whole time rst is asserted
    assign word_ready = r_rdy & ~rst;
    assign w_valid    = r_valid;
    assign w_data     = r_valid ? r_win[0] : '0;
    assign w_round    = r_round;
    assign w_first    = r_valid && (r_round == 6'd0);
    assign w_last     = r_valid && (r_round == 6'(NUM_ROUNDS - 1));
    assign block_done = r_done;

endmodule

// File: tb/tb_sha256_w_schedule.sv
// Bench for sha256_w_schedule: spec-constant vector table, array-based
// reference expansion, and hand sequences for stall, backpressure, abort and reset.
module tb_sha256_w_schedule;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort = 1'b0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [31:0] word_data = '0;
    logic        w_valid;
    logic        w_next = 1'b0;
    logic [31:0] w_data;
    logic [5:0]  w_round;
    logic        w_first;
    logic        w_last;
    logic        block_done;

    sha256_w_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .w_valid    (w_valid),
        .w_next     (w_next),
        .w_data     (w_data),
        .w_round    (w_round),
        .w_first    (w_first),
        .w_last     (w_last),
        .block_done (block_done)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] exp_w [64];
    logic [31:0] got   [64];
    int load_cycles;
    int accepts;

    typedef struct {
        string        nm;
        logic [511:0] blk;
        int           rnd;
        logic [31:0]  exp;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [511:0] b, input int i);
        return b[511-32*i -: 32];
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Reference expansion of a whole block into all 64 schedule words
    task automatic model(input logic [511:0] b);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) exp_w[t] = wd(b, t);
            else exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
        return b;
    endfunction

    // Called at a negedge; returns at the negedge after the 16th accept.
    task automatic load_block(input logic [511:0] b, input bit toggle);
        int  i;
        bit  acc;
        bit  ph;
        i = 0;
        ph = 1'b1;
        load_cycles = 0;
        accepts = 0;
        model(b);
        while (i < 16 && load_cycles < 100) begin
            if (i == 0) begin
                chk("load_w_valid", {31'b0, w_valid}, 32'd0);
                chk("load_w_data", w_data, 32'd0);
            end
            word_valid = toggle ? ph : 1'b1;
            word_data  = toggle && !ph ? $urandom : wd(b, i);
            ph = ~ph;
            acc = word_valid && word_ready;
            @(negedge clk);
            load_cycles++;
            if (acc) begin
                i++;
                accepts++;
            end
        end
        word_valid = 1'b0;
        chk("load_accepts", accepts, 16);
        chk("w0_latency_valid", {31'b0, w_valid}, 32'd1);
    endtask

    // Issues rounds until stop_at (64 = whole block). mode 1 stalls 5 clks at
    // round 30, mode 2 randomises w_next.
    task automatic run_rounds(input int stop_at, input int mode);
        int t;
        int cyc;
        int st;
        bit nx;
        t = 0;
        cyc = 0;
        st = 0;
        while (t < stop_at && cyc < 1000) begin
            cyc++;
            if (!w_valid) begin
                chk("run_w_valid", {31'b0, w_valid}, 32'd1);
                break;
            end
            chk($sformatf("w_round t=%0d", t), {26'b0, w_round}, t);
            chk($sformatf("W[%0d]", t), w_data, exp_w[t]);
            got[t] = w_data;
            if (t == 0) chk("w_first", {31'b0, w_first}, 32'd1);
            if (t == 63) chk("w_last", {31'b0, w_last}, 32'd1);
            if (t == 30 || t == 5) begin
                chk("w_first_mid", {31'b0, w_first}, 32'd0);
                chk("w_last_mid", {31'b0, w_last}, 32'd0);
                chk("ready_in_run", {31'b0, word_ready}, 32'd0);
            end
            if (mode == 2) nx = 1'($urandom_range(0, 1));
            else if (mode == 1 && t == 30 && st < 5) nx = 1'b0;
            else nx = 1'b1;
            if (mode == 1 && t == 30 && !nx) st++;
            w_next = nx;
            // words offered during RUN must be ignored
            word_valid = 1'($urandom_range(0, 1));
            word_data = $urandom;
            @(negedge clk);
            if (nx) t++;
        end
        w_next = 1'b0;
        word_valid = 1'b0;
        if (cyc >= 1000) chk("run_timeout", cyc, 0);
        if (stop_at == 64) begin
            chk("block_done_pulse", {31'b0, block_done}, 32'd1);
            chk("done_w_valid", {31'b0, w_valid}, 32'd0);
            chk("done_word_ready", {31'b0, word_ready}, 32'd1);
        end
    endtask

    logic [511:0] abc;
    logic [511:0] zero_blk;
    logic [511:0] rb;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
        zero_blk = '0;
        vt.push_back('{"abc_W0",  abc, 0,  32'h61626380});
        vt.push_back('{"abc_W15", abc, 15, 32'h00000018});
        vt.push_back('{"abc_W16", abc, 16, 32'h61626380});
        vt.push_back('{"abc_W17", abc, 17, 32'h000F0000});
        vt.push_back('{"abc_W63", abc, 63, 32'h12B1EDEB});
        vt.push_back('{"zero_W16", zero_blk, 16, 32'h0});
        vt.push_back('{"zero_W63", zero_blk, 63, 32'h0});

        #1;
        chk("rst_word_ready", {31'b0, word_ready}, 32'd0);
        chk("rst_w_valid", {31'b0, w_valid}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, word_ready}, 32'd1);
        chk("post_rst_done", {31'b0, block_done}, 32'd0);
        chk("post_rst_round", {26'b0, w_round}, 32'd0);

        for (int k = 0; k < vt.size(); k++) begin
            if (k == 0 || vt[k].blk != vt[k-1].blk) begin
                load_block(vt[k].blk, 1'b0);
                run_rounds(64, 0);
                @(negedge clk);
                chk("done_one_cycle", {31'b0, block_done}, 32'd0);
            end
            chk(vt[k].nm, got[vt[k].rnd], vt[k].exp);
        end

        for (int r = 0; r < 3; r++) begin
            load_block(rand_blk(), 1'b0);
            run_rounds(64, 2);
            @(negedge clk);
        end

        load_block(rand_blk(), 1'b0);
        run_rounds(64, 1);
        @(negedge clk);

        load_block(rand_blk(), 1'b1);
        chk("toggle_ready_run", {31'b0, word_ready}, 32'd0);
        run_rounds(64, 0);
        @(negedge clk);

        load_block(abc, 1'b0);
        run_rounds(40, 0);
        chk("pre_abort_round", {26'b0, w_round}, 32'd40);
        abort = 1'b1;
        w_next = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        w_next = 1'b0;
        chk("abort_w_valid", {31'b0, w_valid}, 32'd0);
        chk("abort_round", {26'b0, w_round}, 32'd0);
        chk("abort_ready", {31'b0, word_ready}, 32'd1);
        chk("abort_done", {31'b0, block_done}, 32'd0);
        load_block(abc, 1'b0);
        run_rounds(64, 0);
        chk("abort_abc_W63", got[63], 32'h12B1EDEB);
        chk("abort_abc_W17", got[17], 32'h000F0000);

        rb = rand_blk();
        load_block(rb, 1'b0);
        chk("b2b_load_clks", load_cycles, 16);
        chk("b2b_W0", w_data, wd(rb, 0));
        run_rounds(64, 0);

        load_block(rand_blk(), 1'b0);
        run_rounds(20, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_w_valid", {31'b0, w_valid}, 32'd0);
        chk("midrst_ready", {31'b0, word_ready}, 32'd1);
        chk("midrst_round", {26'b0, w_round}, 32'd0);
        chk("midrst_done", {31'b0, block_done}, 32'd0);
        load_block(abc, 1'b0);
        run_rounds(64, 0);
        chk("midrst_abc_W63", got[63], 32'h12B1EDEB);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
